// File: rtl/fm_radio_pkg.sv
// -----------------------------------------------------------------------------
// fm_radio_pkg
//   Constants, state type and fixed-point helper used by the FM demodulator.
//   Q10 fixed point: BITS fractional bits. QUAD1 is pi/4 in Q10 and QUAD3 is
//   3*pi/4. mul_frac is the Q10 multiply: the full signed product shifted
//   arithmetically right by BITS, so it rounds toward minus infinity.
//   Callers sign-extend their operands to 64 bits first. The low DATA_WIDTH
//   bits of the result are exact provided DATA_WIDTH + BITS <= 64.
// -----------------------------------------------------------------------------
package fm_radio_pkg;

    localparam int BITS       = 10;
    localparam int QUAD1      = 804;
    localparam int QUAD3      = 2412;
    localparam int DEMOD_GAIN = 758;

    typedef enum logic [2:0] {
        S_READ,
        S_MULT,
        S_DIV_PREP,
        S_DIV_WAIT,
        S_ANGLE,
        S_GAIN,
        S_WRITE
    } demod_state_t;

    function automatic logic signed [63:0] mul_frac(input logic signed [63:0] a,
                                                    input logic signed [63:0] b);
        logic signed [63:0] p;
        p = a * b;
        return p >>> BITS;
    endfunction

endpackage

// File: rtl/fm_demod_if.sv
// -----------------------------------------------------------------------------
// fm_demod_if
//   FIFO-side signals of the FM demodulator. The block pops the channel FIR's
//   real and imaginary output FIFOs and pushes the audio-path FIFO.
//   The master modport is the demodulator. The slave modport is the FIFO side.
//     real_in/imag_in       : I/Q sample at the head of each input FIFO
//     real_empty/imag_empty : input FIFO empty flags
//     real_rd_en/imag_rd_en : input FIFO pops, always asserted together
//     demod_out/demod_wr_en : demodulated sample and output FIFO push
//     demod_full            : output FIFO full
// -----------------------------------------------------------------------------
interface fm_demod_if #(
    parameter int DATA_WIDTH = 32
);
    logic signed [DATA_WIDTH-1:0] real_in;
    logic signed [DATA_WIDTH-1:0] imag_in;
    logic signed [DATA_WIDTH-1:0] demod_out;
    logic                         real_empty;
    logic                         real_rd_en;
    logic                         imag_empty;
    logic                         imag_rd_en;
    logic                         demod_wr_en;
    logic                         demod_full;

    modport master (
        input  real_in, real_empty, imag_in, imag_empty, demod_full,
        output real_rd_en, imag_rd_en, demod_out, demod_wr_en
    );

    modport slave (
        output real_in, real_empty, imag_in, imag_empty, demod_full,
        input  real_rd_en, imag_rd_en, demod_out, demod_wr_en
    );
endinterface

// File: rtl/div_signed.sv
// -----------------------------------------------------------------------------
// div_signed
//   Restoring divider that produces one quotient bit per cycle. It divides the
//   magnitudes and then applies the sign, so the quotient truncates toward
//   zero. The first quotient bit is computed on the start cycle. done therefore
//   pulses for one cycle exactly DATA_WIDTH cycles after start. quotient holds
//   its value until the next start.
//   Ports: clock, reset (sync, active high), start, dividend, divisor,
//          quotient, done.
//   The divisor must be nonzero.
// -----------------------------------------------------------------------------
module div_signed #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic signed [DATA_WIDTH-1:0] dividend,
    input  logic signed [DATA_WIDTH-1:0] divisor,
    output logic signed [DATA_WIDTH-1:0] quotient,
    output logic                         done
);
    localparam int DW = DATA_WIDTH;
    localparam int CW = $clog2(DW);

    logic [DW-1:0] rem_q, dvd_q, dsr_q;
    logic [CW-1:0] cnt_q;
    logic          neg_q, done_q;

    logic [DW-1:0] src_rem, src_dvd, src_dsr, rem_d, dvd_d;
    logic [DW:0]   trial, diff;
    logic          qbit;

    function automatic logic [DW-1:0] mag(input logic signed [DW-1:0] v);
        return v[DW-1] ? -v : v;
    endfunction

    // One restoring step. On start the step runs on the freshly loaded
    // operands, so the first quotient bit costs no extra cycle.
    always_comb begin
        src_rem = start ? '0 : rem_q;
        src_dvd = start ? mag(dividend) : dvd_q;
        src_dsr = start ? mag(divisor) : dsr_q;
        trial   = {src_rem, src_dvd[DW-1]};
        diff    = trial - {1'b0, src_dsr};
        if (trial >= {1'b0, src_dsr}) begin
            rem_d = diff[DW-1:0];
            qbit  = 1'b1;
        end else begin
            rem_d = trial[DW-1:0];
            qbit  = 1'b0;
        end
        // The dividend shifts out at the top while quotient bits shift in at the bottom.
        dvd_d = {src_dvd[DW-2:0], qbit};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rem_q  <= '0;
            dvd_q  <= '0;
            dsr_q  <= '0;
            cnt_q  <= '0;
            neg_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                rem_q <= rem_d;
                dvd_q <= dvd_d;
                dsr_q <= src_dsr;
                neg_q <= dividend[DW-1] ^ divisor[DW-1];
                cnt_q <= CW'(DW - 1);
            end else if (cnt_q != '0) begin
                rem_q  <= rem_d;
                dvd_q  <= dvd_d;
                cnt_q  <= cnt_q - CW'(1);
                done_q <= (cnt_q == CW'(1));
            end
        end
    end

    assign quotient = neg_q ? -dvd_q : dvd_q;
    assign done     = done_q;

endmodule

// File: rtl/fm_demod.sv
// -----------------------------------------------------------------------------
// fm_demod
//   FM discriminator. It pops one I/Q pair from the FIR output FIFOs and
//   conjugate-multiplies it with the previous pair. It then takes the phase
//   with a qarctan approximation, applies the audio gain and pushes one Q10
//   sample.
//   The latency from pop to push is DATA_WIDTH+5 cycles. Samples do not overlap.
//   Ports: clock, reset (sync, active high), bus (fm_demod_if.master).
//   BITS must match fm_radio_pkg::BITS, which mul_frac uses.
// -----------------------------------------------------------------------------
module fm_demod #(
    parameter int DATA_WIDTH = 32,
    parameter int BITS       = fm_radio_pkg::BITS,
    parameter int GAIN       = fm_radio_pkg::DEMOD_GAIN
) (
    input  logic          clock,
    input  logic          reset,
    fm_demod_if.master    bus
);
    import fm_radio_pkg::*;

    localparam int DW = DATA_WIDTH;
    localparam logic signed [DW-1:0] Q1 = DW'(QUAD1);
    localparam logic signed [DW-1:0] Q3 = DW'(QUAD3);
    localparam logic signed [DW-1:0] G  = DW'(GAIN);

    demod_state_t          state_q;
    logic signed [DW-1:0]  cur_r_q, cur_i_q, prev_r_q, prev_i_q;
    logic signed [DW-1:0]  x_q, y_q, q_q, angle_q, result_q;

    logic signed [DW-1:0]  abs_y, num, den, angle_d, quot;
    logic                  pop, push, div_done;

    function automatic logic signed [DW-1:0] mulq(input logic signed [DW-1:0] a,
                                                  input logic signed [DW-1:0] b);
        logic signed [63:0] p;
        p = mul_frac(64'(a), 64'(b));
        return p[DW-1:0];
    endfunction

    // Gating with reset prevents a pop or push at the edge where reset is
    // sampled. Otherwise that sample would be lost or pushed twice.
    assign pop  = (state_q == S_READ) && !reset && !bus.real_empty && !bus.imag_empty;
    assign push = (state_q == S_WRITE) && !reset && !bus.demod_full;

    assign bus.real_rd_en  = pop;
    assign bus.imag_rd_en  = pop;
    assign bus.demod_wr_en = push;
    assign bus.demod_out   = push ? result_q : '0;

    // qarctan operands. The +1 on |y| keeps den >= 1, so there is no
    // divide-by-zero case.
    always_comb begin
        abs_y = (y_q[DW-1] ? -y_q : y_q) + DW'(1);
        if (!x_q[DW-1]) begin
            num = (x_q - abs_y) << BITS;
            den = x_q + abs_y;
        end else begin
            num = (x_q + abs_y) << BITS;
            den = abs_y - x_q;
        end
        angle_d = (x_q[DW-1] ? Q3 : Q1) - mulq(Q1, q_q);
        if (y_q[DW-1]) begin
            angle_d = -angle_d;
        end
    end

    div_signed #(
        .DATA_WIDTH (DW)
    ) u_div (
        .clock    (clock),
        .reset    (reset),
        .start    (state_q == S_DIV_PREP),
        .dividend (num),
        .divisor  (den),
        .quotient (quot),
        .done     (div_done)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_READ;
            cur_r_q  <= '0;
            cur_i_q  <= '0;
            prev_r_q <= '0;
            prev_i_q <= '0;
            x_q      <= '0;
            y_q      <= '0;
            q_q      <= '0;
            angle_q  <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                S_READ: begin
                    if (pop) begin
                        cur_r_q <= bus.real_in;
                        cur_i_q <= bus.imag_in;
                        state_q <= S_MULT;
                    end
                end
                S_MULT: begin
                    // cur * conj(prev): x is the real part and y the imaginary part
                    x_q      <= mulq(prev_r_q, cur_r_q) + mulq(prev_i_q, cur_i_q);
                    y_q      <= mulq(prev_r_q, cur_i_q) - mulq(prev_i_q, cur_r_q);
                    prev_r_q <= cur_r_q;
                    prev_i_q <= cur_i_q;
                    state_q  <= S_DIV_PREP;
                end
                S_DIV_PREP: begin
                    state_q <= S_DIV_WAIT;
                end
                S_DIV_WAIT: begin
                    if (div_done) begin
                        q_q     <= quot;
                        state_q <= S_ANGLE;
                    end
                end
                S_ANGLE: begin
                    angle_q <= angle_d;
                    state_q <= S_GAIN;
                end
                S_GAIN: begin
                    result_q <= mulq(G, angle_q);
                    state_q  <= S_WRITE;
                end
                S_WRITE: begin
                    if (!bus.demod_full) begin
                        state_q <= S_READ;
                    end
                end
                default: state_q <= S_READ;
            endcase
        end
    end

endmodule

// File: tb/tb_fm_demod.sv
// -----------------------------------------------------------------------------
// tb_fm_demod
//   Bench for fm_demod. The input FIFOs are queues. A plain-integer model
//   produces the expected sample at each pop. Pushes are checked for value and
//   for pop-to-push latency. The stimulus is directed vectors followed by random
//   I/Q values with random output backpressure.
// -----------------------------------------------------------------------------
module tb_fm_demod;
    localparam int DW  = 32;
    localparam int LAT = DW + 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fm_demod_if #(.DATA_WIDTH(DW)) bus();

    fm_demod #(.DATA_WIDTH(DW)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    int  vec, errs, cyc;
    int  fr[$], fi[$];
    int  exp_q[$];
    int  got_cnt, pop_cnt, pop_cyc, last_out;
    bit  in_flight, full_seen, hold_i;
    int  mpr, mpi;

    task automatic chk(input string tag, input longint act, input longint exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Q10 multiply with floor rounding, using 64-bit integer arithmetic
    function automatic int mq(input int a, input int b);
        longint p;
        p = longint'(a) * longint'(b);
        return int'(p >>> 10);
    endfunction

    // Phase of cur*conj(prev) via qarctan, scaled by the gain. int wraps mod 2^32.
    function automatic int model(input int r, input int i);
        int x, y, ay, num, den, q, ang;
        x = mq(mpr, r) + mq(mpi, i);
        y = mq(mpr, i) - mq(mpi, r);
        mpr = r;
        mpi = i;
        ay = ((y < 0) ? -y : y) + 1;
        if (x >= 0) begin
            num = (x - ay) * 1024;
            den = x + ay;
        end else begin
            num = (x + ay) * 1024;
            den = ay - x;
        end
        q   = num / den;
        ang = ((x >= 0) ? 804 : 2412) - mq(804, q);
        if (y < 0) ang = -ang;
        return mq(758, ang);
    endfunction

    task automatic drive();
        bus.real_empty = (fr.size() == 0);
        bus.imag_empty = (fi.size() == 0) || hold_i;
        bus.real_in    = (fr.size() != 0) ? fr[0] : 0;
        bus.imag_in    = (fi.size() != 0) ? fi[0] : 0;
    endtask

    task automatic send(input int r, input int i);
        fr.push_back(r);
        fi.push_back(i);
        drive();
    endtask

    // One clock: observe at negedge, then update the FIFO model after the edge.
    task automatic tick();
        bit popped;
        popped = 1'b0;
        @(negedge clk);
        cyc++;
        if (bus.demod_full && in_flight) full_seen = 1'b1;
        if (bus.real_rd_en || bus.imag_rd_en) begin
            chk("rd_en_pair", {bus.real_rd_en, bus.imag_rd_en}, 2'b11);
            chk("pop_nonempty", bus.real_empty | bus.imag_empty, 0);
            chk("pop_no_overlap", in_flight, 0);
            popped = 1'b1;
            pop_cnt++;
            if (fr.size() != 0) exp_q.push_back(model(fr[0], fi[0]));
            pop_cyc   = cyc;
            in_flight = 1'b1;
            full_seen = bus.demod_full;
        end
        if (bus.demod_wr_en) begin
            got_cnt++;
            last_out = bus.demod_out;
            chk("push_not_full", bus.demod_full, 0);
            if (exp_q.size() != 0) chk("demod_out", bus.demod_out, exp_q.pop_front());
            else                   chk("spurious_push", 1, 0);
            if (!full_seen) chk("latency", cyc - pop_cyc, LAT);
            in_flight = 1'b0;
        end else begin
            chk("idle_out_zero", bus.demod_out, 0);
        end
        @(posedge clk);
        #1;
        if (popped && fr.size() != 0) begin
            void'(fr.pop_front());
            void'(fi.pop_front());
        end
        drive();
    endtask

    task automatic wait_got(input int n, input int budget);
        int t;
        t = 0;
        while (got_cnt < n && t < budget) begin
            tick();
            t++;
        end
        chk("push_count", got_cnt, n);
    endtask

    task automatic clear_model();
        mpr = 0;
        mpi = 0;
        exp_q.delete();
        in_flight = 1'b0;
        full_seen = 1'b0;
    endtask

    initial begin
        int r, i, n, t, p0, g0;
        int dr[4], di[4];
        vec = 0; errs = 0; cyc = 0;
        got_cnt = 0; pop_cnt = 0; pop_cyc = 0; last_out = 0;
        hold_i = 1'b0;
        bus.demod_full = 1'b0;
        clear_model();

        // The FIFO holds a sample during reset. It must stay unpopped until reset is released.
        send(1024, 0);
        repeat (3) tick();
        chk("rst_no_pop", pop_cnt, 0);
        chk("rst_no_push", got_cnt, 0);
        rst = 1'b0;
        clear_model();

        wait_got(1, LAT + 10);
        chk("first_sample", last_out, 1190);
        send(1024, 0);
        wait_got(2, LAT + 10);
        chk("same_phase", last_out, 1);
        send(0, -1024);
        wait_got(3, LAT + 10);
        chk("neg_quarter", last_out, -1191);

        // Only the real FIFO is non-empty, so nothing may be popped.
        hold_i = 1'b1;
        send(500, 300);
        p0 = pop_cnt;
        repeat (20) tick();
        chk("one_empty_no_pop", pop_cnt, p0);
        chk("one_empty_no_push", got_cnt, 3);
        hold_i = 1'b0;
        drive();
        wait_got(4, LAT + 10);

        // The output is full while the result is ready, so the result must be held.
        bus.demod_full = 1'b1;
        send(700, -200);
        send(-300, 900);
        p0 = pop_cnt;
        repeat (LAT + 10) tick();
        chk("full_one_pop", pop_cnt, p0 + 1);
        chk("full_no_push", got_cnt, 4);
        bus.demod_full = 1'b0;
        tick();
        chk("full_release_push", got_cnt, 5);
        wait_got(6, 2 * LAT);

        // Directed vectors: negative x, pure quadrature, a diagonal and a small value
        dr = '{-1024, 0, 1024, -2048};
        di = '{0, 1024, 1024, -5};
        for (int k = 0; k < 4; k++) begin
            send(dr[k], di[k]);
            wait_got(7 + k, LAT + 10);
        end

        // Random samples with random backpressure
        for (int k = 0; k < 40; k++) begin
            r = int'($urandom_range(0, 8000)) - 4000;
            i = int'($urandom_range(0, 8000)) - 4000;
            repeat ($urandom_range(0, 3)) tick();
            send(r, i);
            n = got_cnt + 1;
            t = 0;
            while (got_cnt < n && t < 400) begin
                bus.demod_full = ($urandom_range(0, 3) == 0);
                tick();
                t++;
            end
            chk("rand_push", got_cnt, n);
        end
        bus.demod_full = 1'b0;
        drive();

        // Reset during the divide. It must drop the sample and clear the history.
        send(600, 400);
        p0 = pop_cnt;
        repeat (7) tick();
        chk("mid_popped", pop_cnt, p0 + 1);
        g0 = got_cnt;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        clear_model();
        send(1024, 0);
        wait_got(g0 + 1, LAT + 20);
        chk("post_reset_first", last_out, 1190);
        repeat (LAT + 10) tick();
        chk("post_reset_no_extra", got_cnt, g0 + 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fm_demod.md
Name: fm_demod

Overview:
- Downstream neighbour of the complex channel FIR. It pops one decimated I/Q sample pair from the FIR's real and imag output FIFOs.
- It computes the phase difference to the previous sample: conjugate-multiply, then a qarctan approximation with an iterative divider, then a gain stage.
- It pushes one signed Q10 demodulated sample into the audio-path FIFO.
- Its output feeds the audio low-pass/decimation stages.

Parameters:
- DATA_WIDTH, 32, sample width in two's complement, Q10 fixed point.
- BITS, 10, fractional bits.
- GAIN, 758, Q10 demodulation gain.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- real_in  in  DATA_WIDTH  I sample from the FIR real FIFO.
- real_empty  in  1  real FIFO empty.
- real_rd_en  out  1  real FIFO pop.
- imag_in  in  DATA_WIDTH  Q sample from the FIR imag FIFO.
- imag_empty  in  1  imag FIFO empty.
- imag_rd_en  out  1  imag FIFO pop.
- demod_out  out  DATA_WIDTH  demodulated sample.
- demod_wr_en  out  1  output FIFO push.
- demod_full  in  1  output FIFO full.

Behaviour:
- Reset (synchronous, active-high): state=READ; prev_r=prev_i=0; all datapath registers 0; real_rd_en=imag_rd_en=demod_wr_en=0; demod_out=0.
- Reset mid-operation aborts any division, discards the sample in flight and clears the previous-sample history.
- mul(a,b) = bits [DATA_WIDTH+BITS-1:BITS] of the full signed product, i.e. an arithmetic shift right (floor).
- FSM states: READ, MULT, DIV_PREP, DIV_WAIT, ANGLE, GAIN, WRITE.
- READ:
  - Pop only when !real_empty && !imag_empty. real_rd_en and imag_rd_en are always equal and never asserted on a single empty.
  - On the pop, latch cur_r/cur_i and go to MULT. Otherwise stay in READ.
- MULT:
  - x = mul(prev_r,cur_r) + mul(prev_i,cur_i).
  - y = mul(prev_r,cur_i) − mul(prev_i,cur_r).
  - Then prev ← cur.
- DIV_PREP:
  - abs_y = |y| + 1.
  - If x ≥ 0: num = (x − abs_y) << BITS, den = x + abs_y.
  - Else: num = (x + abs_y) << BITS, den = abs_y − x.
  - Pulse the divider start for 1 cycle. den ≥ 1 always, so there is no divide-by-zero path.
- DIV_WAIT: wait for the divider done pulse. Quotient q truncates toward zero.
- ANGLE:
  - If x ≥ 0: angle = QUAD1 − mul(QUAD1,q). Else: angle = QUAD3 − mul(QUAD1,q).
  - If y < 0, negate angle.
- GAIN: result = mul(GAIN, angle).
- WRITE:
  - If !demod_full: demod_wr_en=1 with demod_out=result for exactly 1 cycle, then go to READ.
  - Otherwise hold result, assert no pops, and stay in WRITE.
  - demod_out is 0 whenever demod_wr_en=0.
- Timing: latency from pop to push is DATA_WIDTH+5 cycles when not full. Throughput is 1 sample per DATA_WIDTH+6 cycles. There is no input/output overlap.
- Overflow: sums wrap modulo 2^DATA_WIDTH; no saturation.

Decomposition:
- Shared package fm_radio_pkg holds:
  - BITS.
  - QUAD1 = 804 (π/4 Q10) and QUAD3 = 2412.
  - DEMOD_GAIN = 758.
  - Function mul_frac(a,b).
  - Demodulator state typedef.
- Sub-module div_signed (param DATA_WIDTH), a restoring divider at 1 quotient bit per cycle:
  - Ports: clock, reset, start, dividend, divisor, quotient, done.
  - Signed by magnitude-divide plus sign fix-up.
  - done pulses DATA_WIDTH cycles after start.

Test Plan:
- First sample after reset: (1024,0) pushed (prev=0 → x=y=0, q=−1024, angle=1608) → demod_out=1190, latency DATA_WIDTH+5 from pop.
- After (1024,0), push (1024,0) (x=1024, y=0, q=1022, angle=2) → demod_out=1.
- After (1024,0), push (0,−1024) (x=0, y=−1024, angle=−1608) → demod_out=−1191.
- Only one FIFO non-empty (imag_empty=1, real_empty=0) for 20 cycles → no rd_en asserted, FSM stays in READ.
- demod_full=1 held 10 cycles when result is ready → demod_wr_en=0, no pops; then release → exactly one push of the held value.
- Reset asserted during DIV_WAIT, then release and feed (1024,0) → first output 1190 (history cleared), no spurious push.
